block_stats_streamer: RTL and testbench

//  Source-side driver for the per-block statistics units (mean, variance).
//  - Captures one block of TOTAL_SAMPLES pixels from an upstream valid/ready stream.
//  - Replays the block twice on the start-pulse + back-to-back sample bus the units consume.
//    - Pass 0 goes to the mean unit.
//    - Pass 1 goes to the variance unit, with the captured mean.
//  - Presents {mean, variance} on a valid/ready result port.

---
 rtl/block_stats_pkg.sv | 7 +
 rtl/sample_block_buffer.sv | 20 ++
 rtl/block_stats_streamer.sv | 158 +++++++++++++++
 tb/tb_block_stats_streamer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/block_stats_pkg.sv
// block_stats_pkg: shared FSM state type and default sizing for the block statistics streamer.
package block_stats_pkg;
  typedef enum logic [2:0] {FILL, PASS0, WAIT0, PASS1, WAIT1, DONE} state_e;
  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_TOTAL_SAMPLES = 64;
  localparam int DEF_PAD_CYCLES    = 2;
endpackage

// File: rtl/sample_block_buffer.sv
// sample_block_buffer: one-write/one-read register array holding a block of samples, combinational read.
module sample_block_buffer
  import block_stats_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_TOTAL_SAMPLES,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/block_stats_streamer.sv
// block_stats_streamer: captures a pixel block and replays it to the mean then variance unit.
// BLOCK_STATS_STREAMER_PINGPONG_EN adds a second buffer so the next block fills while the current one is processed.
module block_stats_streamer
  import block_stats_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int TOTAL_SAMPLES = DEF_TOTAL_SAMPLES,
  parameter int PAD_CYCLES    = DEF_PAD_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    in_ready,
  output logic                    stream_start,
  output logic [DATA_WIDTH-1:0]   stream_data,
  output logic                    stream_sel,
  output logic [DATA_WIDTH-1:0]   stream_mean,
  input  logic [DATA_WIDTH-1:0]   mean_in,
  input  logic                    mean_ready,
  input  logic [2*DATA_WIDTH-1:0] variance_in,
  input  logic                    variance_ready,
  output logic [DATA_WIDTH-1:0]   result_mean,
  output logic [2*DATA_WIDTH-1:0] result_variance,
  output logic                    result_valid,
  input  logic                    result_ready
);
  localparam int ADDR_W = $clog2(TOTAL_SAMPLES);
  localparam int CW = ADDR_W + 2;
  localparam logic [CW-1:0] N_SAMP = CW'(TOTAL_SAMPLES);
  localparam logic [CW-1:0] N_PAD = CW'(TOTAL_SAMPLES + PAD_CYCLES);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic start_q, start_d, sel_q, sel_d, in_ready_q, in_ready_d, rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, smean_q, smean_d, rmean_q, rmean_d, rd_data;
  logic [2*DATA_WIDTH-1:0] rvar_q, rvar_d;
  logic wr_en, fill_done, block_avail, go;
  assign wr_en = in_valid && in_ready_q;
  assign fill_done = wr_en && (&wr_idx_q);
`ifdef BLOCK_STATS_STREAMER_PINGPONG_EN
  logic wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d, pend_q, pend_d;
  logic [DATA_WIDTH-1:0] rd0, rd1;
  sample_block_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(TOTAL_SAMPLES)) u_buf0 (
    .clk(clk), .we(wr_en && !wr_buf_q), .waddr(wr_idx_q), .wdata(in_data),
    .raddr(cnt_q[ADDR_W-1:0]), .rdata(rd0));
  sample_block_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(TOTAL_SAMPLES)) u_buf1 (
    .clk(clk), .we(wr_en && wr_buf_q), .waddr(wr_idx_q), .wdata(in_data),
    .raddr(cnt_q[ADDR_W-1:0]), .rdata(rd1));
  assign rd_data = rd_buf_q ? rd1 : rd0;
  assign block_avail = fill_done || pend_q;
  // a pending block lives in the buffer not being written, since wr_buf toggled when it completed
  always_comb begin
    wr_buf_d = wr_buf_q ^ fill_done;
    rd_buf_d = go ? (fill_done ? wr_buf_q : ~wr_buf_q) : rd_buf_q;
    pend_d = go ? 1'b0 : (pend_q || fill_done);
    in_ready_d = !pend_d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_buf_q <= 1'b0;
      rd_buf_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      wr_buf_q <= wr_buf_d;
      rd_buf_q <= rd_buf_d;
      pend_q <= pend_d;
    end
`else
  sample_block_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(TOTAL_SAMPLES)) u_buf (
    .clk(clk), .we(wr_en), .waddr(wr_idx_q), .wdata(in_data),
    .raddr(cnt_q[ADDR_W-1:0]), .rdata(rd_data));
  assign block_avail = fill_done;
  assign in_ready_d = state_d == FILL;
`endif
  // cnt_q is the pass-relative cycle currently on the bus; next-cycle outputs are computed from it
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    start_d = 1'b0;
    data_d = '0;
    sel_d = sel_q;
    smean_d = smean_q;
    rmean_d = rmean_q;
    rvar_d = rvar_q;
    rvalid_d = rvalid_q;
    wr_idx_d = wr_en ? wr_idx_q + 1'b1 : wr_idx_q;
    go = 1'b0;
    case (state_q)
      FILL: go = block_avail;
      PASS0, PASS1: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q < N_SAMP) data_d = rd_data;
        else if (cnt_q < N_PAD) data_d = state_q == PASS1 ? smean_q : '0;
        else state_d = state_q == PASS0 ? WAIT0 : WAIT1;
      end
      WAIT0: if (mean_ready) begin
        smean_d = mean_in;
        rmean_d = mean_in;
        state_d = PASS1;
        start_d = 1'b1;
        cnt_d = '0;
        sel_d = 1'b1;
      end
      WAIT1: if (variance_ready) begin
        rvar_d = variance_in;
        rvalid_d = 1'b1;
        state_d = DONE;
      end
      DONE: if (result_ready) begin
        rvalid_d = 1'b0;
        state_d = FILL;
        go = block_avail;
      end
      default: state_d = FILL;
    endcase
    if (go) begin
      state_d = PASS0;
      start_d = 1'b1;
      cnt_d = '0;
      sel_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= FILL;
      wr_idx_q <= '0;
      cnt_q <= '0;
      start_q <= 1'b0;
      data_q <= '0;
      sel_q <= 1'b0;
      smean_q <= '0;
      rmean_q <= '0;
      rvar_q <= '0;
      rvalid_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      wr_idx_q <= wr_idx_d;
      cnt_q <= cnt_d;
      start_q <= start_d;
      data_q <= data_d;
      sel_q <= sel_d;
      smean_q <= smean_d;
      rmean_q <= rmean_d;
      rvar_q <= rvar_d;
      rvalid_q <= rvalid_d;
      in_ready_q <= in_ready_d;
    end
  assign in_ready = in_ready_q;
  assign stream_start = start_q;
  assign stream_data = data_q;
  assign stream_sel = sel_q;
  assign stream_mean = smean_q;
  assign result_mean = rmean_q;
  assign result_variance = rvar_q;
  assign result_valid = rvalid_q;
endmodule

// File: tb/tb_block_stats_streamer.sv
// tb_block_stats_streamer: random blocks streamed through the DUT, acting as mean/variance units, checked against arithmetic block statistics.
module tb_block_stats_streamer;
  typedef logic [7:0] blk_t [64];
`ifdef BLOCK_STATS_STREAMER_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, mean_ready = 1'b0, variance_ready = 1'b0, result_ready = 1'b0;
  logic in_ready, stream_start, stream_sel, result_valid;
  logic [7:0] in_data = '0, mean_in = '0, stream_data, stream_mean, result_mean;
  logic [15:0] variance_in = '0, result_variance;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  block_stats_streamer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stream_start(stream_start), .stream_data(stream_data), .stream_sel(stream_sel),
    .stream_mean(stream_mean), .mean_in(mean_in), .mean_ready(mean_ready),
    .variance_in(variance_in), .variance_ready(variance_ready), .result_mean(result_mean),
    .result_variance(result_variance), .result_valid(result_valid), .result_ready(result_ready));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic void model(input blk_t s, output int m, output int v);
    int sum = 0;
    foreach (s[i]) sum += int'(s[i]);
    m = sum / 64;
    v = 0;
    foreach (s[i]) v += (int'(s[i]) - m) * (int'(s[i]) - m);
    v = v / 64;
  endfunction
  function automatic blk_t rand_blk();
    blk_t s;
    foreach (s[i]) s[i] = 8'($urandom);
    return s;
  endfunction
  task automatic fill(input blk_t s, input bit gaps);
    int n = 0;
    int c = 0;
    while (n < 64 && c < 1000) begin
      in_valid = !gaps || (c % 3 == 0);
      in_data = s[n];
      if (in_valid && in_ready) n++;
      c++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("fill_count", n, 64);
  endtask
  task automatic pass(input string tag, input bit sel, input blk_t s, input logic [7:0] pad, output int sum, output int sq);
    int d;
    sum = 0;
    sq = 0;
    chk({tag, "_start"}, stream_start, 1);
    chk({tag, "_data0"}, stream_data, 0);
    chk({tag, "_sel0"}, stream_sel, sel);
    for (int k = 1; k <= 66; k++) begin
      @(negedge clk);
      d = int'(stream_data);
      sum += d;
      sq += (d - int'(pad)) * (d - int'(pad));
      chk({tag, "_data"}, stream_data, k <= 64 ? s[k-1] : pad);
      chk({tag, "_nostart"}, stream_start, 0);
      chk({tag, "_sel"}, stream_sel, sel);
    end
  endtask
  task automatic mean_phase(input int sum, input int m);
    repeat (3) @(negedge clk);
    chk("wait0_quiet", stream_start, 0);
    mean_ready = 1'b1;
    mean_in = 8'(sum / 64);
    @(negedge clk);
    mean_ready = 1'b0;
    mean_in = 8'($urandom);
    chk("stream_mean", stream_mean, m);
  endtask
  task automatic var_phase(input int sq);
    repeat (3) @(negedge clk);
    chk("wait1_quiet", result_valid, 0);
    variance_ready = 1'b1;
    variance_in = 16'(sq / 64);
    @(negedge clk);
    variance_ready = 1'b0;
    variance_in = 16'($urandom);
  endtask
  task automatic accept(input string tag, input int hold, input bit ir, input int m, input int v);
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_valid"}, result_valid, 1);
      chk({tag, "_hold_mean"}, result_mean, m);
      chk({tag, "_hold_var"}, result_variance, v);
      chk({tag, "_hold_ir"}, in_ready, ir);
      @(negedge clk);
    end
    chk({tag, "_valid"}, result_valid, 1);
    chk({tag, "_mean"}, result_mean, m);
    chk({tag, "_var"}, result_variance, v);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk({tag, "_valid_drop"}, result_valid, 0);
    chk({tag, "_ir_after"}, in_ready, 1);
  endtask
  task automatic run_rest(input string tag, input blk_t s, input int hold);
    int m, v, sum, sq;
    model(s, m, v);
    pass({tag, "_p0"}, 1'b0, s, 8'd0, sum, sq);
    chk({tag, "_busy_ir"}, in_ready, PP);
    mean_phase(sum, m);
    pass({tag, "_p1"}, 1'b1, s, 8'(m), sum, sq);
    var_phase(sq);
    accept(tag, hold, PP, m, v);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    blk_t s, b;
    int m, v, sum, sq, mb, vb;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_start", stream_start, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_rvar", result_variance, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    foreach (s[i]) s[i] = 8'(i);
    fill(s, 1'b0);
    run_rest("ramp", s, 10);
    chk("ramp_idle_start", stream_start, 0);
    s = rand_blk();
    fill(s, 1'b1);
    run_rest("gaps", s, 2);
    s = rand_blk();
    model(s, m, v);
    fill(s, 1'b0);
    pass("rst_p0", 1'b0, s, 8'd0, sum, sq);
    mean_phase(sum, m);
    repeat (21) @(negedge clk);
    chk("rst_pre_data", stream_data, s[20]);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_start", stream_start, 0);
    chk("midrst_data", stream_data, 0);
    chk("midrst_sel", stream_sel, 0);
    chk("midrst_smean", stream_mean, 0);
    chk("midrst_rmean", result_mean, 0);
    chk("midrst_valid", result_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    s = rand_blk();
    fill(s, 1'b0);
    run_rest("post_rst", s, 3);
    if (PP) begin
      s = rand_blk();
      b = rand_blk();
      model(s, m, v);
      fill(s, 1'b0);
      pass("ppa_p0", 1'b0, s, 8'd0, sum, sq);
      mean_phase(sum, m);
      pass("ppa_p1", 1'b1, s, 8'(m), sum, sq);
      fill(b, 1'b1);
      chk("pp_full_ir", in_ready, 0);
      chk("pp_no_early_start", stream_start, 0);
      var_phase(sq);
      accept("ppa", 4, 1'b0, m, v);
      model(b, mb, vb);
      run_rest("ppb", b, 2);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
